bp_be_stride_prefetch_gen: RTL and testbench
============================================

# bp_be_stride_prefetch_gen

Consumer of the loop-inference descriptor (`v`/`yumi`, remaining-iteration count, striding-load PC, effective address, stride) in the BE checker. Accepts one descriptor at a time and emits a bounded stream of prefetch virtual addresses (`base + k*stride`) to the D$ prefetch port over a valid/ready handshake. Issue stops at the iteration count, the depth cap, a page crossing, or a flush. A PC filter suppresses re-prefetching the same loop.

## Interface
- `vaddr_width_p`, 39: virtual address width.
- `eff_addr_width_p`, `vaddr_width_p`: width of the descriptor address and the prefetch address.
- `stride_width_p`, 8: stride width; stride is signed two's complement.
- `output_range_p`, 8: width of the iteration count.
- `max_prefetch_p`, 16: cap on prefetches per descriptor; at least 1.
- `page_offset_width_p`, 12: bits below the page number.
- `clk_i` in 1: the single clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `v_i` in 1: descriptor valid.
- `count_i` in `output_range_p`: remaining iterations.
- `pc_i` in `vaddr_width_p`: striding-load PC.
- `eff_addr_i` in `eff_addr_width_p`: last observed load address (base).
- `stride_i` in `stride_width_p`: signed byte stride.
- `yumi_o` out 1: descriptor consumed this cycle.
- `pf_v_o` out 1: prefetch request valid.
- `pf_addr_o` out `eff_addr_width_p`: prefetch address.
- `pf_ready_i` in 1: prefetch port accepts.
- `flush_i` in 1: abort the stream and clear the filter.
- `busy_o` out 1: state is ISSUE.
- `issued_o` out 16: saturating count of accepted prefetches.

## Operation
**States:** IDLE, ISSUE.

**Descriptor acceptance**
- `yumi_o = v_i & (state==IDLE) & ~flush_i`, combinational.
- On accept, latch:
  - `base_r = eff_addr_i`
  - `stride_r = sext(stride_i)` to `eff_addr_width_p`
  - `rem_r = min(count_i, max_prefetch_p)`
  - `addr_r = base_r + stride_r`
  - `pc_r = pc_i`

**Drop conditions on accept** (descriptor is consumed, state stays IDLE, nothing is issued):
- `rem==0`
- `stride_i==0`
- `last_v_r & pc_i==last_pc_r` (filter hit)

**Normal accept:** go to ISSUE; set `last_pc_r = pc_i` and `last_v_r = 1`.

**ISSUE**
- `pf_v_o=1` and `pf_addr_o=addr_r`.
- On `pf_ready_i`:
  - `rem_r--`
  - `addr_r += stride_r`
  - `issued_o++`, saturating at `0xFFFF`
- Return to IDLE when either:
  - `rem_r==1` at the handshake, or
  - the next address's page (`[eff_addr_width_p-1:page_offset_width_p]`) differs from the page of `base_r`.
- A page-crossing address is never presented.
- If `addr_r`'s own page already differs from `base_r`'s on entry, no request is issued; return to IDLE the cycle after accept.

**Arithmetic:** all addition is modulo `2^eff_addr_width_p`. Wrap-around is not detected except through the page check.

**Flush**
- `flush_i` takes priority over everything else.
- Next state is IDLE and `last_v_r` is cleared.
- `pf_v_o` is forced to 0 in the flush cycle, even mid-handshake; the port must treat this as a cancel.
- `pf_ready_i` in that cycle is ignored and `issued_o` does not increment.
- `v_i` during flush is not consumed.

**Reset** (asynchronous, any cycle, including mid-ISSUE)
- State goes to IDLE.
- `pf_v_o=0`, `pf_addr_o=0`, `yumi_o=0` (combinational on state/`v_i`), `busy_o=0`, `issued_o=0`.
- All latches cleared, including `last_v_r=0`.

## Timing
- Accept at cycle T; first `pf_v_o` at T+1.
- With `pf_ready_i` held high, one request per cycle: N prefetches occupy T+1..T+N.
- IDLE at T+N+1; the next descriptor can be accepted in T+N+1.
- `pf_v_o`/`pf_addr_o` stay stable until `pf_ready_i` or flush.
- Back-pressure stalls with no loss and no address change.
- `busy_o` is registered state (high from T+1).

## Test plan
1. **Basic stream:** `count=3`, `stride=8`, base `0x1000`, `pf_ready_i=1` → `pf_addr_o` 0x1008, 0x1010, 0x1018 at T+1..T+3; `yumi_o` at T; IDLE at T+4; `issued_o=3`.
2. **Cap and negative stride:** `count=200`, `stride=-4` (0xFC), base `0x2100` → exactly 16 requests 0x20FC..0x20C0; same PC resent → consumed, no requests; `issued_o` unchanged.
3. **Page crossing:** base `0x1FF0`, `stride=8`, `count=5` → only 0x1FF8, then IDLE; 0x2000 is never presented.
4. **Back-pressure:** `pf_ready_i` low for 3 cycles mid-stream → address held; total count and order intact.
5. **Flush mid-stream, then reuse:** flush during the 2nd request with `pf_ready_i=1` → `pf_v_o=0` that cycle, `issued_o=1`, IDLE; same PC re-accepted and streams (filter cleared).
6. **Async reset:** `reset_n_i` low mid-ISSUE, off-edge → outputs 0 immediately; `count=0` or `stride=0` descriptor after reset → `yumi_o=1`, no `pf_v_o`.

Source files
------------

// File: rtl/bp_be_stride_prefetch_gen.sv
// Turns one loop descriptor into a stream of base+k*stride prefetches; first request the cycle after accept.
// Holds pf_v_o/pf_addr_o under back-pressure; flush cancels the in-flight request and clears the PC filter.
module bp_be_stride_prefetch_gen #(
  parameter int vaddr_width_p       = 39,
  parameter int eff_addr_width_p    = vaddr_width_p,
  parameter int stride_width_p      = 8,
  parameter int output_range_p      = 8,
  parameter int max_prefetch_p      = 16,
  parameter int page_offset_width_p = 12
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  input  logic [output_range_p-1:0]   count_i,
  input  logic [vaddr_width_p-1:0]    pc_i,
  input  logic [eff_addr_width_p-1:0] eff_addr_i,
  input  logic [stride_width_p-1:0]   stride_i,
  output logic                        yumi_o,
  output logic                        pf_v_o,
  output logic [eff_addr_width_p-1:0] pf_addr_o,
  input  logic                        pf_ready_i,
  input  logic                        flush_i,
  output logic                        busy_o,
  output logic [15:0]                 issued_o
);

  localparam int pg_w = eff_addr_width_p - page_offset_width_p;

  typedef enum logic {e_idle, e_issue} state_e;
  state_e state_r, state_n;

  logic [eff_addr_width_p-1:0] stride_sext, stride_r, addr_r, addr_nxt;
  logic [pg_w-1:0]             base_pg_r;
  logic [output_range_p-1:0]   rem_r, rem_cap;
  logic [vaddr_width_p-1:0]    last_pc_r;
  logic                        last_v_r;
  logic [15:0]                 issued_r;
  logic                        drop, hs, page_ok, nxt_page_ok;

  assign stride_sext = {{(eff_addr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
  assign addr_nxt    = addr_r + stride_r;
  assign page_ok     = (addr_r[eff_addr_width_p-1:page_offset_width_p] == base_pg_r);
  assign nxt_page_ok = (addr_nxt[eff_addr_width_p-1:page_offset_width_p] == base_pg_r);

  always_comb begin
    rem_cap = count_i;
    if (32'(count_i) > 32'(max_prefetch_p))
      rem_cap = output_range_p'(max_prefetch_p);
  end

  assign drop = (rem_cap == '0) | (stride_i == '0) | (last_v_r & (pc_i == last_pc_r));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    yumi_o  = 1'b0;
    pf_v_o  = 1'b0;
    hs      = 1'b0;
    if (flush_i) begin
      state_n = e_idle;
    end else begin
      case (state_r)
        e_idle: begin
          yumi_o = v_i;
          if (v_i && !drop) state_n = e_issue;
        end
        e_issue: begin
          // An address already outside the base page is never presented.
          pf_v_o = page_ok;
          hs     = page_ok & pf_ready_i;
          if (!page_ok)
            state_n = e_idle;
          else if (hs && ((rem_r == output_range_p'(1)) || !nxt_page_ok))
            state_n = e_idle;
        end
        default: state_n = e_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      base_pg_r <= '0;
      stride_r  <= '0;
      rem_r     <= '0;
      addr_r    <= '0;
      last_pc_r <= '0;
      last_v_r  <= 1'b0;
      issued_r  <= '0;
    end else begin
      if (yumi_o) begin
        base_pg_r <= eff_addr_i[eff_addr_width_p-1:page_offset_width_p];
        stride_r  <= stride_sext;
        rem_r     <= rem_cap;
        addr_r    <= eff_addr_i + stride_sext;
      end else if (hs) begin
        rem_r  <= rem_r - output_range_p'(1);
        addr_r <= addr_nxt;
      end
      if (hs && (issued_r != 16'hFFFF))
        issued_r <= issued_r + 16'd1;
      if (flush_i) begin
        last_v_r <= 1'b0;
      end else if (yumi_o && !drop) begin
        last_v_r  <= 1'b1;
        last_pc_r <= pc_i;
      end
    end
  end

  assign busy_o    = (state_r == e_issue);
  assign pf_addr_o = busy_o ? addr_r : '0;
  assign issued_o  = issued_r;

endmodule

// File: tb/tb_bp_be_stride_prefetch_gen.sv
// Directed vector table plus hand-written back-pressure, flush and async-reset sequences.
module tb_bp_be_stride_prefetch_gen;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic [7:0]  count_i;
  logic [38:0] pc_i;
  logic [38:0] eff_addr_i;
  logic [7:0]  stride_i;
  logic        yumi_o;
  logic        pf_v_o;
  logic [38:0] pf_addr_o;
  logic        pf_ready_i;
  logic        flush_i;
  logic        busy_o;
  logic [15:0] issued_o;

  always #5 clk_i = ~clk_i;

  bp_be_stride_prefetch_gen dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .count_i(count_i),
    .pc_i(pc_i), .eff_addr_i(eff_addr_i), .stride_i(stride_i), .yumi_o(yumi_o),
    .pf_v_o(pf_v_o), .pf_addr_o(pf_addr_o), .pf_ready_i(pf_ready_i),
    .flush_i(flush_i), .busy_o(busy_o), .issued_o(issued_o)
  );

  typedef struct {
    logic [38:0] pc;
    logic [38:0] base;
    logic [7:0]  stride;
    logic [7:0]  count;
    int          n;
    logic [38:0] first;
    logic [38:0] last;
  } vec_t;

  vec_t        vecs [11];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_issued = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [38:0] sx(input logic [7:0] s);
    return {{31{s[7]}}, s};
  endfunction

  // Present a descriptor for one cycle; leaves the bench at the negedge after accept.
  task automatic accept(input vec_t d);
    @(negedge clk_i);
    v_i = 1'b1; pc_i = d.pc; eff_addr_i = d.base; stride_i = d.stride; count_i = d.count;
    #1 chk("yumi", yumi_o, 1);
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  task automatic run_desc(input vec_t d);
    logic [38:0] ea;
    logic [38:0] last_seen;
    int          k;
    bit          done;
    accept(d);
    chk("first_pf_v", pf_v_o, (d.n > 0));
    ea = d.first; k = 0; last_seen = '0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pf_v_o) begin
        chk("pf_addr", pf_addr_o, ea);
        last_seen = pf_addr_o;
        ea = ea + sx(d.stride);
        k++;
      end
      if (!busy_o) begin
        done = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    chk("stream_end", done, 1);
    chk("n_req", k, d.n);
    if (d.n > 0) chk("last_addr", last_seen, d.last);
    exp_issued = exp_issued + 16'(d.n);
    chk("issued", issued_o, exp_issued);
  endtask

  initial begin
    vec_t d;
    reset_n_i = 1'b1; v_i = 1'b0; count_i = '0; pc_i = '0; eff_addr_i = '0;
    stride_i = '0; pf_ready_i = 1'b1; flush_i = 1'b0;
    #1 reset_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_pf_v", pf_v_o, 0);
    chk("rst_pf_addr", pf_addr_o, 0);
    chk("rst_yumi", yumi_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_issued", issued_o, 0);
    reset_n_i = 1'b1;

    //           pc      base            stride  count n   first           last
    vecs[0]  = '{39'h100, 39'h1000,       8'h08, 8'd3,   3,  39'h1008,       39'h1018};
    vecs[1]  = '{39'h200, 39'h2100,       8'hFC, 8'd200, 16, 39'h20FC,       39'h20C0};
    vecs[2]  = '{39'h200, 39'h3000,       8'h04, 8'd5,   0,  39'h0,          39'h0};
    vecs[3]  = '{39'h300, 39'h1FF0,       8'h08, 8'd5,   1,  39'h1FF8,       39'h1FF8};
    vecs[4]  = '{39'h400, 39'h5000,       8'h00, 8'd4,   0,  39'h0,          39'h0};
    vecs[5]  = '{39'h500, 39'h6000,       8'h10, 8'd0,   0,  39'h0,          39'h0};
    vecs[6]  = '{39'h600, 39'h7FF8,       8'h08, 8'd3,   0,  39'h0,          39'h0};
    vecs[7]  = '{39'h700, 39'h0,          8'h80, 8'd2,   0,  39'h0,          39'h0};
    vecs[8]  = '{39'h800, 39'h9000,       8'h7F, 8'd4,   4,  39'h907F,       39'h91FC};
    vecs[9]  = '{39'h900, 39'hA000,       8'h01, 8'd16,  16, 39'hA001,       39'hA010};
    vecs[10] = '{39'hA00, 39'hB000,       8'h40, 8'd1,   1,  39'hB040,       39'hB040};

    for (int i = 0; i < 11; i++) run_desc(vecs[i]);

    // Back-pressure: three stalled cycles on the second request.
    d = '{39'hB00, 39'hC000, 8'h08, 8'd4, 4, 39'hC008, 39'hC020};
    accept(d);
    chk("bp_first", pf_addr_o, 39'hC008);
    @(negedge clk_i);
    pf_ready_i = 1'b0;
    chk("bp_pre", pf_addr_o, 39'hC010);
    repeat (3) begin
      @(negedge clk_i);
      chk("bp_hold_v", pf_v_o, 1);
      chk("bp_hold_addr", pf_addr_o, 39'hC010);
    end
    pf_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_v", pf_v_o, 1);
      chk("bp_addr", pf_addr_o, 39'hC010 + 39'(8 * i));
      @(negedge clk_i);
    end
    chk("bp_idle", busy_o, 0);
    exp_issued = exp_issued + 16'd4;
    chk("bp_issued", issued_o, exp_issued);

    // Flush during the second request, then the same PC streams again.
    d = '{39'hC00, 39'hD000, 8'h04, 8'd5, 5, 39'hD004, 39'hD014};
    accept(d);
    chk("fl_first", pf_addr_o, 39'hD004);
    @(negedge clk_i);
    chk("fl_second", pf_addr_o, 39'hD008);
    flush_i = 1'b1;
    #1 chk("fl_pf_v", pf_v_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("fl_idle", busy_o, 0);
    exp_issued = exp_issued + 16'd1;
    chk("fl_issued", issued_o, exp_issued);
    run_desc(d);

    // Descriptor during an idle flush is not consumed.
    @(negedge clk_i);
    v_i = 1'b1; pc_i = 39'hD00; eff_addr_i = 39'hE000; stride_i = 8'h08; count_i = 8'd2;
    flush_i = 1'b1;
    #1 chk("fl_yumi", yumi_o, 0);
    @(negedge clk_i);
    v_i = 1'b0; flush_i = 1'b0;
    chk("fl_no_start", busy_o, 0);

    // Asynchronous reset mid-stream, away from the clock edge.
    d = '{39'hE00, 39'hE000, 8'h08, 8'd10, 10, 39'hE008, 39'hE050};
    accept(d);
    chk("ar_pf_v", pf_v_o, 1);
    @(negedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    chk("ar_pf_v0", pf_v_o, 0);
    chk("ar_addr0", pf_addr_o, 0);
    chk("ar_busy0", busy_o, 0);
    chk("ar_issued0", issued_o, 0);
    chk("ar_yumi0", yumi_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    exp_issued = '0;
    run_desc('{39'hE00, 39'hF000, 8'h08, 8'd0, 0, 39'h0, 39'h0});
    run_desc('{39'hF00, 39'hF000, 8'h00, 8'd3, 0, 39'h0, 39'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
